// File: rtl/multi_phase_signal_ctrl_if.sv
// Bundle of demand inputs and signal-head outputs for the phase controller.
// Latency: none (wires only).
// Backpressure: none; demand is level-sensitive and outputs are always valid.
interface multi_phase_signal_ctrl_if #(
    parameter int N_PHASES    = 2,
    parameter int TIMER_WIDTH = 4
);
    localparam int PHASE_W = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;

    // Timing strobe and demand from the debounced switch block.
    logic                     tick;
    logic [N_PHASES-1:0]      car_req;
    logic                     ped_req;

    // Signal heads towards the LED drivers plus status.
    logic [3*N_PHASES-1:0]    light;
    logic [1:0]               light_ped;
    logic [PHASE_W-1:0]       phase;
    logic [TIMER_WIDTH-1:0]   timer_out;

    // Side that provides demand and consumes the light pattern.
    modport master (
        output tick, car_req, ped_req,
        input  light, light_ped, phase, timer_out
    );

    // The controller itself.
    modport slave (
        input  tick, car_req, ped_req,
        output light, light_ped, phase, timer_out
    );
endinterface

// File: rtl/multi_phase_signal_ctrl.sv
// Round-robin traffic-signal controller: N vehicle phases + one pedestrian phase.
// Latency: state/phase registered; lights decoded from registers, change the cycle after the edge.
// Backpressure: none; demand is latched every clk and served when the sequencer reaches it.
module multi_phase_signal_ctrl #(
    parameter int N_PHASES    = 2,
    parameter int TIMER_WIDTH = 4,
    parameter int GREEN_MIN   = 3,
    parameter int GREEN_MAX   = 8,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    parameter int WALK_TIME   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_phase_signal_ctrl_if.slave bus
);

    localparam int PHASE_W = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;

    localparam logic [TIMER_WIDTH-1:0] TIMER_SAT  = '1;
    localparam logic [PHASE_W-1:0]     LAST_PHASE = PHASE_W'(N_PHASES - 1);
    localparam logic [PHASE_W:0]       N_WIDE     = (PHASE_W + 1)'(N_PHASES);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_WALK    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
    logic [N_PHASES-1:0]     pending_q, pending_d;
    logic                    ped_pending_q, ped_pending_d;

    // Timer as a signed integer so threshold checks against small
    // parameters (possibly zero) stay ordinary signed comparisons.
    int                      timer_int;

    // Round-robin search results.
    logic                    rr_found;
    logic [PHASE_W-1:0]      rr_idx;
    logic [PHASE_W:0]        rr_sum;
    logic [PHASE_W-1:0]      rr_cand;

    // Green-phase decision terms.
    logic [N_PHASES-1:0]     phase_onehot;
    logic                    competing;
    logic                    own_demand;

    // Demand capture terms.
    logic [N_PHASES-1:0]     car_set;
    logic                    entering_green;
    logic                    entering_walk;

    assign timer_int    = int'(timer_q);
    assign phase_onehot = N_PHASES'(1) << phase_q;
    assign competing    = ped_pending_q | (|(pending_q & ~phase_onehot));
    assign own_demand   = bus.car_req[phase_q];

    // Find the first pending phase after the current one, wrapping around;
    // the current phase itself is checked last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = phase_q;
        rr_sum   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= N_PHASES; k++) begin
            rr_sum = {1'b0, phase_q} + (PHASE_W + 1)'(k);
            if (rr_sum >= N_WIDE) begin
                rr_sum = rr_sum - N_WIDE;
            end
            rr_cand = rr_sum[PHASE_W-1:0];
            if (!rr_found && pending_q[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Next-state logic: every transition is gated by the tick strobe.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        unique case (state_q)
            ST_ALL_RED: begin
                // Once the clearance interval is over, keep re-evaluating on
                // every tick so a saturated rest-in-red reacts to new demand.
                if (bus.tick && timer_int >= ALLRED_TIME - 1) begin
                    if (ped_pending_q) begin
                        state_d = ST_WALK;
                    end else if (rr_found) begin
                        state_d = ST_GREEN;
                        phase_d = rr_idx;
                    end
                end
            end
            ST_GREEN: begin
                // Held demand on the served phase extends green up to the
                // maximum; green only ends when someone else is waiting.
                if (bus.tick && competing &&
                    timer_int >= GREEN_MIN - 1 &&
                    (!own_demand || timer_int >= GREEN_MAX - 1)) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (bus.tick && timer_int == YELLOW_TIME - 1) begin
                    state_d = ST_ALL_RED;
                end
            end
            ST_WALK: begin
                // phase is left alone so vehicle service resumes after the
                // phase that was served before the walk.
                if (bus.tick && timer_int == WALK_TIME - 1) begin
                    state_d = ST_ALL_RED;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
            end
        endcase
    end

    // Timer: cleared on any state change, otherwise counts ticks and saturates.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (bus.tick && timer_q != TIMER_SAT) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Demand latching runs every clk; entry into service clears the served
    // request and that clear beats a same-cycle set.
    always_comb begin
        car_set = bus.car_req;
        if (state_q == ST_GREEN) begin
            car_set[phase_q] = 1'b0;
        end
        entering_green = (state_d == ST_GREEN) && (state_q != ST_GREEN);
        entering_walk  = (state_d == ST_WALK)  && (state_q != ST_WALK);

        pending_d = pending_q | car_set;
        if (entering_green) begin
            pending_d[phase_d] = 1'b0;
        end

        ped_pending_d = ped_pending_q | (bus.ped_req && (state_q != ST_WALK));
        if (entering_walk) begin
            ped_pending_d = 1'b0;
        end
    end

    // State register; reset discards all latched demand.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ALL_RED;
            phase_q       <= LAST_PHASE;
            timer_q       <= '0;
            pending_q     <= '0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Lamp decode: only the selected phase can show green or yellow.
    always_comb begin
        bus.light = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            bus.light[3*i +: 3] = LAMP_RED;
            if (phase_q == PHASE_W'(i)) begin
                if (state_q == ST_GREEN) begin
                    bus.light[3*i +: 3] = LAMP_GREEN;
                end else if (state_q == ST_YELLOW) begin
                    bus.light[3*i +: 3] = LAMP_YELLOW;
                end
            end
        end
        bus.light_ped = (state_q == ST_WALK) ? 2'b01 : 2'b10;
    end

    assign bus.phase     = phase_q;
    assign bus.timer_out = timer_q;

endmodule
